// File: rtl/loop_addr_gen.sv
// Nested-loop address generator: cascaded bounded counters stream base + sum(idx_i*stride_i) on valid/ready.
// Optional per-loop rollover flags on output wrap are enabled with `define LOOP_ADDR_GEN_WRAP_FLAGS_EN.
module loop_addr_gen #(
  parameter int NUM_LOOPS  = 3,
  parameter int CNT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr,
  input  logic                            start,
  input  logic [ADDR_WIDTH-1:0]           base,
  input  logic [NUM_LOOPS*CNT_WIDTH-1:0]  bounds,
  input  logic [NUM_LOOPS*ADDR_WIDTH-1:0] strides,
  output logic [ADDR_WIDTH-1:0]           addr,
  output logic [NUM_LOOPS*CNT_WIDTH-1:0]  idx,
  output logic                            valid,
  input  logic                            ready,
  output logic                            last,
  output logic                            busy,
`ifdef LOOP_ADDR_GEN_WRAP_FLAGS_EN
  output logic [NUM_LOOPS-1:0]            wrap,
`endif
  output logic                            done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]  bound_q  [NUM_LOOPS];
  logic [CNT_WIDTH-1:0]  bound_d  [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0] stride_q [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0] stride_d [NUM_LOOPS];
  logic [CNT_WIDTH-1:0]  idx_q    [NUM_LOOPS];
  logic [CNT_WIDTH-1:0]  idx_d    [NUM_LOOPS];
  // row_q[k] is the address with loops below k at zero; row_q[0] is the live address.
  logic [ADDR_WIDTH-1:0] row_q    [NUM_LOOPS];
  logic [ADDR_WIDTH-1:0] row_d    [NUM_LOOPS];

  logic [NUM_LOOPS-1:0]  at_max;
  logic [NUM_LOOPS:0]    low_max;
  logic                  all_max;
  logic                  run;
  logic                  fire;
  logic [ADDR_WIDTH-1:0] carry_row;

  assign run  = (state_q == S_RUN);
  assign fire = run & ready;

  // Carry chain: low_max[k] means every loop below k sits at its final index.
  always_comb begin
    low_max[0] = 1'b1;
    for (int k = 0; k < NUM_LOOPS; k++) begin
      at_max[k]      = (idx_q[k] == (bound_q[k] - CNT_WIDTH'(1)));
      low_max[k+1]   = low_max[k] & at_max[k];
    end
  end

  assign all_max = low_max[NUM_LOOPS];

  // Exactly one level increments on a non-final beat; lower levels restart from its new row.
  always_comb begin
    carry_row = '0;
    for (int k = 0; k < NUM_LOOPS; k++) begin
      if (low_max[k] && !at_max[k]) begin
        carry_row = row_q[k] + stride_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_RUN;
        S_RUN:   if (fire && all_max) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_LOOPS; k++) begin
      bound_d[k]  = bound_q[k];
      stride_d[k] = stride_q[k];
      idx_d[k]    = idx_q[k];
      row_d[k]    = row_q[k];
    end
    if (clr) begin
      for (int k = 0; k < NUM_LOOPS; k++) begin
        bound_d[k]  = '0;
        stride_d[k] = '0;
        idx_d[k]    = '0;
        row_d[k]    = '0;
      end
    end else if ((state_q == S_IDLE) && start) begin
      for (int k = 0; k < NUM_LOOPS; k++) begin
        // A zero trip count behaves as one so the loop stays pinned at index 0.
        bound_d[k]  = (bounds[k*CNT_WIDTH +: CNT_WIDTH] == '0) ?
                      CNT_WIDTH'(1) : bounds[k*CNT_WIDTH +: CNT_WIDTH];
        stride_d[k] = strides[k*ADDR_WIDTH +: ADDR_WIDTH];
        idx_d[k]    = '0;
        row_d[k]    = base;
      end
    end else if (fire && !all_max) begin
      for (int k = 0; k < NUM_LOOPS; k++) begin
        if (low_max[k] && at_max[k]) begin
          idx_d[k] = '0;
          row_d[k] = carry_row;
        end else if (low_max[k]) begin
          idx_d[k] = idx_q[k] + CNT_WIDTH'(1);
          row_d[k] = carry_row;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      for (int k = 0; k < NUM_LOOPS; k++) begin
        bound_q[k]  <= '0;
        stride_q[k] <= '0;
        idx_q[k]    <= '0;
        row_q[k]    <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int k = 0; k < NUM_LOOPS; k++) begin
        bound_q[k]  <= bound_d[k];
        stride_q[k] <= stride_d[k];
        idx_q[k]    <= idx_d[k];
        row_q[k]    <= row_d[k];
      end
    end
  end

  always_comb begin
    valid = run;
    busy  = run;
    done  = (state_q == S_DONE);
    last  = run & all_max;
    addr  = row_q[0];
    for (int k = 0; k < NUM_LOOPS; k++) begin
      idx[k*CNT_WIDTH +: CNT_WIDTH] = idx_q[k];
    end
  end

`ifdef LOOP_ADDR_GEN_WRAP_FLAGS_EN
  always_comb begin
    for (int k = 0; k < NUM_LOOPS; k++) begin
      wrap[k] = run & low_max[k+1];
    end
  end
`endif

endmodule

// File: tb/tb_loop_addr_gen.sv
// Scoreboard bench for loop_addr_gen: driver queues expected beats, negedge monitor pops and compares.
module tb_loop_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        start;
  logic [15:0] base;
  logic [23:0] bounds;
  logic [47:0] strides;
  logic [15:0] addr;
  logic [23:0] idx;
  logic        valid;
  logic        ready;
  logic        last;
  logic        busy;
  logic        done;
`ifdef LOOP_ADDR_GEN_WRAP_FLAGS_EN
  logic [2:0]  wrap;
`endif

  loop_addr_gen #(.NUM_LOOPS(3), .CNT_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .base(base),
    .bounds(bounds), .strides(strides), .addr(addr), .idx(idx),
    .valid(valid), .ready(ready), .last(last), .busy(busy),
`ifdef LOOP_ADDR_GEN_WRAP_FLAGS_EN
    .wrap(wrap),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic [23:0] idx;
    logic        last;
    logic [2:0]  wrap;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic        hold_pend = 1'b0;
  logic [15:0] hold_addr;
  logic [23:0] hold_idx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every accepted beat is matched against the head of the expectation queue.
  always @(negedge clk) begin
    beat_t e;
    if (!rst) begin
      if (hold_pend && valid) begin
        check("hold_addr", 64'(addr), 64'(hold_addr));
        check("hold_idx", 64'(idx), 64'(hold_idx));
      end
      hold_pend = valid && !ready;
      hold_addr = addr;
      hold_idx  = idx;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got addr %0h with empty queue", addr);
        end else begin
          e = exp_q.pop_front();
          check("beat_addr", 64'(addr), 64'(e.addr));
          check("beat_idx", 64'(idx), 64'(e.idx));
          check("beat_last", 64'(last), 64'(e.last));
`ifdef LOOP_ADDR_GEN_WRAP_FLAGS_EN
          check("beat_wrap", 64'(wrap), 64'(e.wrap));
`endif
          if (e.last) last_cyc = cyc;
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic push_beat(input logic [15:0] a, input int i2, input int i1, input int i0,
                           input logic l, input logic [2:0] w);
    beat_t b;
    b.addr = a;
    b.idx  = {8'(i2), 8'(i1), 8'(i0)};
    b.last = l;
    b.wrap = w;
    exp_q.push_back(b);
  endtask

  // Reference: plain nested loops with multiplication.
  task automatic push_sweep(input logic [15:0] b, input int b2, input int b1, input int b0,
                            input logic [15:0] s2, input logic [15:0] s1, input logic [15:0] s0,
                            output int n);
    int e0, e1, e2;
    logic [15:0] a;
    logic w0, w1, w2;
    e0 = (b0 == 0) ? 1 : b0;
    e1 = (b1 == 0) ? 1 : b1;
    e2 = (b2 == 0) ? 1 : b2;
    n = 0;
    for (int i2 = 0; i2 < e2; i2++)
      for (int i1 = 0; i1 < e1; i1++)
        for (int i0 = 0; i0 < e0; i0++) begin
          a  = 16'(32'(b) + i0 * 32'(s0) + i1 * 32'(s1) + i2 * 32'(s2));
          w0 = (i0 == e0 - 1);
          w1 = w0 && (i1 == e1 - 1);
          w2 = w1 && (i2 == e2 - 1);
          push_beat(a, i2, i1, i0, w2, {w2, w1, w0});
          n++;
        end
  endtask

  task automatic run_sweep(input string name, input logic [15:0] b, input int b2, input int b1,
                           input int b0, input logic [15:0] s2, input logic [15:0] s1,
                           input logic [15:0] s0, input int n, input bit bp);
    int start_cyc;
    bit seen;
    @(posedge clk); #1;
    base    = b;
    bounds  = {8'(b2), 8'(b1), 8'(b0)};
    strides = {s2, s1, s0};
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
    check({name, "_first_valid"}, 64'(valid), 64'd1);
    check({name, "_busy"}, 64'(busy), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (bp) begin
        ready = (k % 4 == 0) || (k % 4 == 3);
        if (k == 2) begin
          start = 1'b1;
          base  = 16'h5555;
        end else if (k == 3) begin
          start = 1'b0;
          base  = b;
        end
      end else begin
        ready = 1'b1;
      end
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done want done", name);
    end else begin
      check({name, "_done_lat"}, 64'(cyc - last_cyc), 64'd1);
      check({name, "_all_beats"}, 64'(exp_q.size()), 64'd0);
      check({name, "_done_valid"}, 64'(valid), 64'd0);
      check({name, "_done_busy"}, 64'(busy), 64'd0);
      if (!bp) check({name, "_throughput"}, 64'(cyc - start_cyc), 64'(n));
      ready = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check({name, "_done_pulse"}, 64'(done), 64'd0);
      check({name, "_start_at_done_ignored"}, 64'(valid), 64'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b1; clr = 1'b0; start = 1'b0; ready = 1'b0;
    base = '0; bounds = '0; strides = '0;
    #12;
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_idx", 64'(idx), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_last", 64'(last), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 2D sweep, hand table: loop2 bound 0 acts as 1 so its stride never contributes.
    begin
      logic [15:0] tbl [12];
      tbl = '{16'h100, 16'h101, 16'h102, 16'h103, 16'h120, 16'h121,
              16'h122, 16'h123, 16'h140, 16'h141, 16'h142, 16'h143};
      for (int r = 0; r < 2; r++) begin
        for (int k = 0; k < 12; k++)
          push_beat(tbl[k], 0, k / 4, k % 4, k == 11,
                    {k == 11, k == 11, k % 4 == 3});
        run_sweep(r == 0 ? "sweep2d" : "backpressure", 16'h100, 0, 3, 4,
                  16'h1234, 16'h20, 16'h1, 12, r == 1);
      end
    end

    push_sweep(16'h0ABC, 0, 0, 0, 16'h7, 16'h9, 16'h3, n);
    check("degen_beats", 64'(n), 64'd1);
    run_sweep("degen_all0", 16'h0ABC, 0, 0, 0, 16'h7, 16'h9, 16'h3, n, 1'b0);

    push_sweep(16'h0010, 0, 1, 5, 16'h0, 16'h40, 16'h3, n);
    run_sweep("degen_1x5", 16'h0010, 0, 1, 5, 16'h0, 16'h40, 16'h3, n, 1'b0);

    push_sweep(16'h0000, 2, 2, 2, 16'h100, 16'h10, 16'h1, n);
    run_sweep("sweep3d_bp", 16'h0000, 2, 2, 2, 16'h100, 16'h10, 16'h1, n, 1'b1);

    push_beat(16'hFFFE, 0, 0, 0, 1'b0, 3'b000);
    push_beat(16'hFFFF, 0, 0, 1, 1'b0, 3'b000);
    push_beat(16'h0000, 0, 0, 2, 1'b0, 3'b000);
    push_beat(16'h0001, 0, 0, 3, 1'b1, 3'b111);
    run_sweep("addr_wrap", 16'hFFFE, 0, 0, 4, 16'h0, 16'h0, 16'h1, 4, 1'b0);

    // Abort with clr while the second beat is presented.
    push_beat(16'hFFFE, 0, 0, 0, 1'b0, 3'b000);
    push_beat(16'hFFFF, 0, 0, 1, 1'b0, 3'b000);
    @(posedge clk); #1;
    base = 16'hFFFE; bounds = {8'd0, 8'd0, 8'd4}; strides = {16'h0, 16'h0, 16'h1};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ready = 1'b1;
    @(posedge clk); #1;
    check("clr_beat2_addr", 64'(addr), 64'hFFFF);
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr_valid", 64'(valid), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_addr", 64'(addr), 64'd0);
    check("clr_idx", 64'(idx), 64'd0);
    check("clr_done", 64'(done), 64'd0);
    clr = 1'b0; ready = 1'b0;
    @(posedge clk); #1;
    check("clr_no_done", 64'(done), 64'd0);
    check("clr_queue", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    push_sweep(16'hFFFE, 0, 0, 4, 16'h0, 16'h0, 16'h1, n);
    run_sweep("after_clr", 16'hFFFE, 0, 0, 4, 16'h0, 16'h0, 16'h1, n, 1'b0);

    // Asynchronous reset in the middle of a stalled sweep, with start held.
    @(posedge clk); #1;
    base = 16'h0200; bounds = {8'd2, 8'd2, 8'd2}; strides = {16'h100, 16'h10, 16'h1};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(valid), 64'd1);
    #2;
    rst = 1'b1; start = 1'b1;
    #1;
    check("async_rst_addr", 64'(addr), 64'd0);
    check("async_rst_valid", 64'(valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("rst_start_ignored", 64'(valid), 64'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(valid), 64'd0);
    check("post_rst_no_done", 64'(done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
